// File: rtl/lb_io_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lb_io_pkg
// Description : Shared widths, types and defaults for the I/O register injector.
// Revision    : 1.0 - initial release
// ============================================================================
package lb_io_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int WAIT_CNT_W = 8;

  localparam logic [REG_ADDR_W-1:0] IO_REG_DEFAULT = 5'd28;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // A write to r0 is discarded downstream, so that slot can carry an event.
  function automatic logic slot_is_free(input logic ren, input reg_addr_t rd);
    return !ren || (rd == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : io_event_fifo
// Description : Synchronous power-of-two FIFO holding pending input events.
// Revision    : 1.0 - initial release
// ============================================================================
module io_event_fifo
  import lb_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_push,
  input  data_t i_data,
  input  logic  i_pop,
  output logic  o_full,
  output logic  o_empty,
  output data_t o_head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  data_t              r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/io_reg_injector.sv
`default_nettype none
// ============================================================================
// Module      : io_reg_injector
// Description : Merges buffered input events into the regfile write port.
//               Optional drop counter enabled by IO_INJ_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module io_reg_injector
  import lb_io_pkg::*;
#(
  parameter int        DEPTH     = 4,
  parameter reg_addr_t IO_REG    = IO_REG_DEFAULT,
  parameter int        STALL_MAX = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_ren,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        ev_valid,
  input  logic [31:0] ev_data,
  output logic        ev_ready,
  output logic        ren_out,
  output logic [4:0]  rd_out,
  output logic [31:0] data_out,
  output logic        stall_req,
  output logic        pending
`ifdef IO_INJ_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam wait_cnt_t c_stall_max = wait_cnt_t'(STALL_MAX);

  logic      w_full;
  logic      w_empty;
  data_t     w_head;
  logic      w_pending;
  logic      w_inject;
  logic      w_push;
  wait_cnt_t r_wait_cnt;

  assign w_pending = !w_empty;
  assign w_inject  = !reset && w_pending && slot_is_free(wb_ren, wb_rd);
  assign w_push    = !reset && ev_valid && !w_full;

  io_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_data  (ev_data),
    .i_pop   (w_inject),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Saturates so a pipeline that ignores stall_req cannot wrap the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_pending && !w_inject) begin
      if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_comb begin
    ren_out  = 1'b0;
    rd_out   = '0;
    data_out = '0;
    if (!reset) begin
      if (w_inject) begin
        ren_out  = 1'b1;
        rd_out   = IO_REG;
        data_out = w_head;
      end else begin
        ren_out  = wb_ren;
        rd_out   = wb_rd;
        data_out = wb_data;
      end
    end
  end

  assign stall_req = !reset && w_pending && (r_wait_cnt >= c_stall_max);
  assign ev_ready  = !reset && !w_full;
  assign pending   = !reset && w_pending;

`ifdef IO_INJ_DROP_CNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (ev_valid && w_full && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: doc/io_reg_injector.md
# io_reg_injector

Write-side companion to the decode-stage register file. Merges asynchronous game-input events (direction/button codes from the controller peripheral) into the processor's single regfile write port, so software reads player input from a fixed architectural register. Sits between the writeback stage and the decode block's `ren_in` / `rd_in` / `data_write` inputs. Processor writes have priority; events are buffered and injected in free write slots, with a bounded-starvation stall request.

## Interface
- `DEPTH`, 4: event FIFO entries; power of two, 2–16.
- `IO_REG`, 5'd28: destination register for injected events; never 0.
- `STALL_MAX`, 8: cycles a head event may wait before `stall_req` asserts; 1–255.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `wb_ren`  in  1  writeback write enable.
- `wb_rd`  in  5  writeback destination register.
- `wb_data`  in  32  writeback data.
- `ev_valid`  in  1  peripheral event valid.
- `ev_data`  in  32  event payload.
- `ev_ready`  out  1  FIFO can accept; equals !full.
- `ren_out`  out  1  to decode `ren_in`.
- `rd_out`  out  5  to decode `rd_in`.
- `data_out`  out  32  to decode `data_write`.
- `stall_req`  out  1  request pipeline freeze so an event can be injected.
- `pending`  out  1  FIFO non-empty.

## Operation
- Push: `ev_valid && ev_ready` at a rising edge writes `ev_data` at the tail. `ev_valid` while full: event dropped, FIFO unchanged.
- Slot free when `wb_ren == 0` or `wb_rd == 0` (writes to r0 are discarded downstream anyway).
- Inject: slot free and `pending`: `ren_out=1`, `rd_out=IO_REG`, `data_out=head`; head popped at that edge.
- Otherwise pass-through: `ren_out=wb_ren`, `rd_out=wb_rd`, `data_out=wb_data`.
- Processor write to `IO_REG` in the same cycle as a pending event: processor wins; event stays queued and overwrites it in a later slot.
- Starvation: `wait_cnt` (8 bits) increments each cycle `pending` is 1 and no inject occurs; clears on pop or when empty. `stall_req = pending && (wait_cnt >= STALL_MAX)`. Pipeline contract: while `stall_req` is 1, writeback drives `wb_ren=0` combinationally that same cycle, so inject occurs that cycle.
- Simultaneous push and pop: both occur; occupancy unchanged. Push into empty FIFO is not injectable until the following cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy counter has log2(DEPTH)+1 bits, 0..DEPTH.

## Timing
- Outputs `ren_out` / `rd_out` / `data_out` / `stall_req` are combinational from inputs and registered FIFO state. Decode samples them on falling edge.
- Event latency: accepted at edge N, earliest write visible on the port in cycle N+1. Worst-case is (occupancy+1)·(STALL_MAX+1) cycles.
- Reset (any cycle, including mid-stall): FIFO emptied, pointers and `wait_cnt` to 0. While `reset`=1: `ren_out`=0, `rd_out`=0, `data_out`=0, `stall_req`=0, `ev_ready`=0, `pending`=0. After release, `ev_ready`=1 in the first cycle.

## Configuration
- `IO_INJ_DROP_CNT_EN` defined: adds output `drop_count` [15:0]. It increments (saturating at 16'hFFFF) on every `ev_valid` cycle while full, and resets to 0.
- Undefined: port absent; drops are silent; no counter logic.

## Structure
- Shared package `lb_io_pkg`: `REG_ADDR_W`=5, `DATA_W`=32, default `IO_REG` constant, `wait_cnt` width constant.
- Sub-module `io_event_fifo`. It is a synchronous FIFO with push/pop/full/empty/head and a DEPTH parameter. The top holds the arbiter, starvation counter and optional drop counter.

## Test plan
- Idle processor (`wb_ren`=0), push 32'h0000_0002 at edge 0. Required: cycle 1 shows `ren_out`=1, `rd_out`=28, `data_out`=32'h2, and `pending`=0 after the edge.
- Processor writing r5 every cycle, one event queued, `STALL_MAX`=8. Required: `stall_req` rises after 8 waiting cycles; with `wb_ren` forced 0, inject occurs the same cycle and `stall_req` falls.
- Push 5 events with DEPTH=4 and the slot blocked. Required: `ev_ready`=0 after the 4th; the 5th is dropped. With the macro, `drop_count`=1. Unblock: the four payloads are written in order.
- `wb_ren`=1 with `wb_rd`=0 and an event pending. Required: inject occurs and r0 traffic is not forwarded.
- Same cycle: `wb_rd`=28, `wb_data`=32'hAAAA, event 32'h3 pending. Required: port carries 32'hAAAA, then 32'h3 in the next free slot.
- Assert `reset` with 3 events queued and `stall_req`=1. Required: all outputs 0 that cycle; after release `pending`=0 and `ev_ready`=1.
